pulse_train_emitter: RTL and testbench

//  Drives a physical actuator line (coin-return solenoid, dispense motor, status LED) with a train of
//  N fixed-width pulses separated by fixed gaps. Converts a single-cycle command into timed

---
 rtl/pulse_train_emitter_pkg.sv | 14 +
 rtl/pulse_train_emitter_phase_timer.sv | 29 ++
 rtl/pulse_train_emitter.sv | 130 +++++++++++++
 tb/tb_pulse_train_emitter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pulse_train_emitter_pkg.sv
// Shared definitions for the pulse train emitter: FSM state encoding and the
// default pulse/gap lengths also used by the input-conditioning logic.
package pulse_train_emitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int unsigned DEF_ON_CYCLES  = 12000;
  localparam int unsigned DEF_OFF_CYCLES = 12000;

endpackage

// File: rtl/pulse_train_emitter_phase_timer.sv
// Loadable down-counter that times one pulse or gap phase; zero flags the
// final cycle of the phase.
module phase_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt;

  // load wins over decrement; the counter parks at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_emitter.sv
// Emits a train of fixed-width pulses separated by fixed gaps on a registered
// actuator line, in response to a single-cycle start command.
module pulse_train_emitter
  import pulse_train_emitter_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TIMER_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_cycles
    $error("ON_CYCLES and OFF_CYCLES must both be at least 1");
  end
  if ((((64'(ON_CYCLES) - 64'd1) >> TIMER_W) != 64'd0) ||
      (((64'(OFF_CYCLES) - 64'd1) >> TIMER_W) != 64'd0)) begin : g_bad_timer_w
    $error("TIMER_W too narrow for ON_CYCLES/OFF_CYCLES");
  end

  state_t             state_q, state_d;
  logic               pulse_d, busy_d, done_d;
  logic [CNT_W-1:0]   rem_d;
  logic               tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state_q != ST_IDLE),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      state_q   <= state_d;
      pulse_out <= pulse_d;
      busy      <= busy_d;
      done      <= done_d;
      remaining <= rem_d;
    end
  end

  // abort has priority over both start and phase expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !abort && (count != '0)) state_d = ST_ON;
      ST_ON: begin
        if (abort) state_d = ST_IDLE;
        else if (tmr_zero) state_d = (remaining == CNT_W'(1)) ? ST_IDLE : ST_OFF;
      end
      ST_OFF: begin
        if (abort) state_d = ST_IDLE;
        else if (tmr_zero) state_d = ST_ON;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_d  = (state_d == ST_ON);
    busy_d   = (state_d != ST_IDLE);
    done_d   = 1'b0;
    rem_d    = remaining;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d    = count;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
          end
        end
      end
      ST_ON: begin
        if (abort) begin
          rem_d    = '0;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          if (remaining != '0) rem_d = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = OFF_LOAD;
          end
        end
      end
      ST_OFF: begin
        if (abort) begin
          rem_d    = '0;
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      default: begin
        rem_d    = '0;
        tmr_load = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_train_emitter.sv
// Directed bench for pulse_train_emitter with ON_CYCLES=4, OFF_CYCLES=3, CNT_W=4.
module tb_pulse_train_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic       abort = 1'b0;
  logic       pulse_out, busy, done;
  logic [3:0] remaining;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic       s;
    logic [3:0] c;
    logic       a;
    logic       p;
    logic       b;
    logic       d;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[$];

  pulse_train_emitter #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .CNT_W      (4),
    .TIMER_W    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .abort     (abort),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  function automatic void add(string tag, logic s, logic [3:0] c, logic a,
                              logic p, logic b, logic d, logic [3:0] r);
    vec_t v;
    v.tag = tag; v.s = s; v.c = c; v.a = a;
    v.p = p; v.b = b; v.d = d; v.r = r;
    vecs.push_back(v);
  endfunction

  function automatic void rep(string tag, int n, logic p, logic b, logic d, logic [3:0] r);
    for (int i = 0; i < n; i++) add(tag, 1'b0, 4'd0, 1'b0, p, b, d, r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic p, logic b, logic d, logic [3:0] r);
    total++;
    if (pulse_out !== p || busy !== b || done !== d || remaining !== r) begin
      bad++;
      $display("FAIL %s: got pulse=%b busy=%b done=%b rem=%0d, expected pulse=%b busy=%b done=%b rem=%0d",
               tag, pulse_out, busy, done, remaining, p, b, d, r);
    end
  endtask

  initial begin
    // test 1: three pulses of 4, two gaps of 3, busy for 18 cycles
    add("t1_start", 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    rep("t1_on1", 3, 1'b1, 1'b1, 1'b0, 4'd3);
    rep("t1_gap1", 3, 1'b0, 1'b1, 1'b0, 4'd2);
    rep("t1_on2", 4, 1'b1, 1'b1, 1'b0, 4'd2);
    rep("t1_gap2", 3, 1'b0, 1'b1, 1'b0, 4'd1);
    rep("t1_on3", 4, 1'b1, 1'b1, 1'b0, 4'd1);
    rep("t1_done", 1, 1'b0, 1'b0, 1'b1, 4'd0);
    rep("t1_idle", 1, 1'b0, 1'b0, 1'b0, 4'd0);
    // test 2: zero-count request completes immediately
    add("t2_zero", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    rep("t2_idle", 2, 1'b0, 1'b0, 1'b0, 4'd0);
    // test 6a: abort beats start; abort alone in idle does nothing
    add("t6_start_abort", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    add("t6_abort_idle", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    rep("t6_idle", 2, 1'b0, 1'b0, 1'b0, 4'd0);
    // test 3: second start during the gap is ignored
    add("t3_start", 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
    rep("t3_on1", 3, 1'b1, 1'b1, 1'b0, 4'd2);
    add("t3_restart_gap", 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    rep("t3_gap", 2, 1'b0, 1'b1, 1'b0, 4'd1);
    rep("t3_on2", 4, 1'b1, 1'b1, 1'b0, 4'd1);
    rep("t3_done", 1, 1'b0, 1'b0, 1'b1, 4'd0);
    rep("t3_idle", 2, 1'b0, 1'b0, 1'b0, 4'd0);
    // test 4: abort in 2nd cycle of 2nd pulse, then a single pulse
    add("t4_start", 1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    rep("t4_on1", 3, 1'b1, 1'b1, 1'b0, 4'd4);
    rep("t4_gap1", 3, 1'b0, 1'b1, 1'b0, 4'd3);
    rep("t4_on2", 2, 1'b1, 1'b1, 1'b0, 4'd3);
    add("t4_abort", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    rep("t4_no_done", 2, 1'b0, 1'b0, 1'b0, 4'd0);
    add("t4_restart", 1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
    rep("t4_on", 3, 1'b1, 1'b1, 1'b0, 4'd1);
    rep("t4_done", 1, 1'b0, 1'b0, 1'b1, 4'd0);
    rep("t4_idle", 1, 1'b0, 1'b0, 1'b0, 4'd0);
    // test 6b: maximum count, remaining counts down to 0 and stays there
    add("t6_max_start", 1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
    rep("t6_max_on", 3, 1'b1, 1'b1, 1'b0, 4'd15);
    for (int k = 14; k >= 1; k--) begin
      rep("t6_max_gap", 3, 1'b0, 1'b1, 1'b0, 4'(k));
      rep("t6_max_on", 4, 1'b1, 1'b1, 1'b0, 4'(k));
    end
    rep("t6_max_done", 1, 1'b0, 1'b0, 1'b1, 4'd0);
    rep("t6_max_idle", 3, 1'b0, 1'b0, 1'b0, 4'd0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state", 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    step();
    check_all("after_reset_release", 1'b0, 1'b0, 1'b0, 4'd0);

    foreach (vecs[i]) begin
      start = vecs[i].s;
      count = vecs[i].c;
      abort = vecs[i].a;
      step();
      total++;
      if (pulse_out !== vecs[i].p || busy !== vecs[i].b || done !== vecs[i].d ||
          remaining !== vecs[i].r) begin
        bad++;
        $display("FAIL %s row %0d: got pulse=%b busy=%b done=%b rem=%0d, expected pulse=%b busy=%b done=%b rem=%0d",
                 vecs[i].tag, i, pulse_out, busy, done, remaining,
                 vecs[i].p, vecs[i].b, vecs[i].d, vecs[i].r);
      end
    end
    start = 1'b0; count = 4'd0; abort = 1'b0;

    // test 5: asynchronous reset in the middle of a pulse
    start = 1'b1; count = 4'd2;
    step();
    start = 1'b0; count = 4'd0;
    check_all("t5_pulse_started", 1'b1, 1'b1, 1'b0, 4'd2);
    step();
    #3 reset = 1'b1;
    #1 check_all("t5_async_drop", 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("t5_post_reset_idle", 1'b0, 1'b0, 1'b0, 4'd0);
    end
    start = 1'b1; count = 4'd1;
    step();
    start = 1'b0; count = 4'd0;
    check_all("t5_restart", 1'b1, 1'b1, 1'b0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
